// File: rtl/hack_rf_pkg.sv
// Shared definitions for the register-file write path: geometry, FSM
// encoding and a small saturating-increment helper.
package hack_rf_pkg;

    localparam int unsigned RF_DEPTH  = 32;
    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned STARVE_W  = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rf_init_sweeper.sv
// Address generator for the zero-fill sweep: a 5-bit up counter with a
// flag marking the final register address.
module rf_init_sweeper
    import hack_rf_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 restart,
    input  logic                 en,
    output logic [RF_ADDR_W-1:0] addr,
    output logic                 done
);

    // Sweep counter: restart pulls it back to 0, otherwise advance per write.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            addr <= '0;
        end else if (restart) begin
            addr <= '0;
        end else if (en) begin
            addr <= addr + 1'b1;
        end
    end

    assign done = (addr == RF_ADDR_W'(RF_DEPTH - 1));

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-port write arbiter in front of a 2R1W register file. Zero-fills the
// file after reset or clear, then arbitrates core writeback (port 0, default
// priority) against loader/debug (port 1, starvation-protected).
module rf_write_arbiter
    import hack_rf_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter bit          ZERO_R0      = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 clear,
    input  logic                 req0,
    input  logic [RF_ADDR_W-1:0] addr0,
    input  logic [RF_DATA_W-1:0] data0,
    output logic                 gnt0,
    input  logic                 req1,
    input  logic [RF_ADDR_W-1:0] addr1,
    input  logic [RF_DATA_W-1:0] data1,
    output logic                 gnt1,
    output logic                 RF_WE,
    output logic [RF_ADDR_W-1:0] RF_RW,
    output logic [RF_DATA_W-1:0] RF_DW,
    output logic                 init_done
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    rf_state_e              state, state_next;
    logic [STARVE_W-1:0]    starve;
    logic                   force1;
    logic                   sweep_en;
    logic                   sweep_done;
    logic [RF_ADDR_W-1:0]   sweep_addr;
    logic [RF_ADDR_W-1:0]   wr_addr;
    logic [RF_DATA_W-1:0]   wr_data;
    logic                   wr_discard;

    rf_init_sweeper u_sweeper (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .restart (clear),
        .en      (sweep_en),
        .addr    (sweep_addr),
        .done    (sweep_done)
    );

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state, sweep enable and grant decision.
    always_comb begin
        state_next = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        sweep_en   = 1'b0;
        force1     = req1 && (starve == LIMIT);
        case (state)
            ST_INIT: begin
                if (!clear) begin
                    sweep_en = 1'b1;
                    if (sweep_done) state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_next = ST_INIT;
                end else if (req1 && (force1 || !req0)) begin
                    gnt1 = 1'b1;
                end else if (req0) begin
                    gnt0 = 1'b1;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    // Starvation counter for port 1, only meaningful while running.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            starve <= '0;
        end else if (state == ST_RUN && req1 && !gnt1) begin
            starve <= sat_inc(starve);
        end else begin
            starve <= '0;
        end
    end

    assign wr_addr    = gnt1 ? addr1 : addr0;
    assign wr_data    = gnt1 ? data1 : data0;
    assign wr_discard = ZERO_R0 && (wr_addr == '0);

    // Registered drive of the file's write port: sweep zeros, accepted
    // writes, or an idle cycle that holds address/data.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RF_WE <= 1'b0;
            RF_RW <= '0;
            RF_DW <= '0;
        end else if (sweep_en) begin
            RF_WE <= 1'b1;
            RF_RW <= sweep_addr;
            RF_DW <= '0;
        end else if (gnt0 || gnt1) begin
            RF_WE <= !wr_discard;
            RF_RW <= wr_addr;
            RF_DW <= wr_data;
        end else begin
            RF_WE <= 1'b0;
        end
    end

    assign init_done = (state == ST_RUN);

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive cycles port 1 may be denied before it is forced a grant; legal range 1..15.
REQ-002 SHALL have parameter ZERO_R0, default 1: when 1, accepted writes to address 0 are discarded.
REQ-003 CLK  input  1  single clock, all state on rising edge.
REQ-004 RESET_N  input  1  asynchronous active-low reset.
REQ-005 clear  input  1  sync pulse requesting a full register-file clear.
REQ-006 req0 / addr0 / data0  input  1/5/32  port 0 (core writeback) write request, address, data.
REQ-007 gnt0  output  1  port 0 request accepted this cycle.
REQ-008 req1 / addr1 / data1  input  1/5/32  port 1 (loader/debug) write request, address, data.
REQ-009 gnt1  output  1  port 1 request accepted this cycle.
REQ-010 RF_WE / RF_RW / RF_DW  output  1/5/32  registered drive of the 2R1W file's WE, RW, DW.
REQ-011 init_done  output  1  high in RUN state only.

Function
REQ-012 SHALL implement FSM states INIT and RUN.
REQ-013 INIT: SHALL write DW=0 to addresses 0..31 ascending, one per cycle (RF_WE=1), gnt0=gnt1=0, then enter RUN after address 31 is issued.
REQ-014 RUN, clear=1: SHALL enter INIT next cycle, restart at address 0, and grant nothing that cycle.
REQ-015 clear during INIT SHALL restart the sweep at address 0.
REQ-016 gnt0/gnt1 SHALL be combinational from req*, state and the starve counter; at most one high per cycle.
REQ-017 Default priority: port 0 wins when both request.
REQ-018 Starve counter (4 bits) SHALL increment each RUN cycle req1=1 and gnt1=0, clear on gnt1 or req1=0, saturate at 15.
REQ-019 When starve counter = STARVE_LIMIT and req1=1, port 1 SHALL win regardless of req0.
REQ-020 A request SHALL stay valid (req, addr, data held) until granted; non-granted requests are not queued internally.
REQ-021 Accepted request SHALL appear on RF_WE/RF_RW/RF_DW exactly one cycle after grant (latency 1); file updated at the following edge.
REQ-022 Cycles without grant in RUN SHALL drive RF_WE=0; RF_RW/RF_DW hold last value.
REQ-023 ZERO_R0=1 and accepted address 0: gnt SHALL still assert, RF_WE SHALL stay 0.
REQ-024 Back-to-back grants SHALL be sustained at one write per cycle with no bubbles.

Reset
REQ-025 RESET_N low SHALL asynchronously force state=INIT, sweep address=0, starve counter=0, RF_WE=0, RF_RW=0, RF_DW=0, init_done=0, gnt0=gnt1=0.
REQ-026 First INIT write (address 0) SHALL be driven in the first cycle after RESET_N deasserts.
REQ-027 Reset mid-sweep or mid-write SHALL abandon the write; sweep restarts from 0.

Structure
REQ-028 State encoding, RF depth (32), address width (5) and data width (32) SHALL live in shared package hack_rf_pkg.
REQ-029 Sub-module rf_init_sweeper (5-bit counter plus done flag) SHALL generate INIT addresses; arbitration and output registers SHALL stay in the top.

Verification
REQ-030 Reset release, no requests -> RF_WE=1 for 32 cycles, RF_RW 0..31, RF_DW=0; init_done rises in cycle 33.
REQ-031 RUN, req0 addr 5 data 0xDEADBEEF and req1 addr 6 data 0x12345678 held -> gnt0 cycle 0; RF_RW=5 cycle 1; port 1 granted once starve count reaches 4; file ends 5=0xDEADBEEF, 6=0x12345678.
REQ-032 req0 continuous, req1 continuous, STARVE_LIMIT=4 -> gnt1 exactly once every 5 cycles, never with gnt0.
REQ-033 ZERO_R0=1, req0 addr 0 data 0xFFFFFFFF -> gnt0=1, RF_WE stays 0, register 0 reads 0.
REQ-034 clear pulse in RUN with req0 pending -> no grant, 32-cycle zero sweep, then req0 granted the cycle init_done rises.
REQ-035 RESET_N asserted at sweep address 17 -> outputs reset immediately; sweep restarts at 0 after release.
